// File: rtl/unit_arbiter_pkg.sv
// Shared types for the unit arbiter slice: unit selects, data words, memory
// control codes, arbiter FSM states and round-robin index helpers.
package unit_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  unit_sel_t;

  localparam unit_sel_t UNIT_SEL_ALU = 2'd0;
  localparam unit_sel_t UNIT_SEL_MEM = 2'd1;

  localparam word_t MEM_CTRL_READ  = 32'd0;
  localparam word_t MEM_CTRL_WRITE = 32'd1;

  typedef enum logic {
    UNIT_ARB_IDLE = 1'b0,
    UNIT_ARB_BUSY = 1'b1
  } unit_arb_state_t;

  // Wrap written as compare-and-subtract so non-power-of-two counts stay exact.
  function automatic int rr_index(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

  function automatic int ptr_next(input int idx, input int n);
    return rr_index(idx, 1, n);
  endfunction

endpackage

// File: rtl/unit_arbiter_if.sv
// Thread-array, ALU and memory-port signal bundle for unit_arbiter.
// stall_cnt exists only when UNIT_ARB_STATS_EN is defined.
interface unit_arbiter_if
  import unit_arbiter_pkg::*;
#(
  parameter int N_THREADS = 4
);

  logic [N_THREADS-1:0] req;
  unit_sel_t            req_sel  [N_THREADS];
  word_t                req_ctrl [N_THREADS];
  word_t                req_in0  [N_THREADS];
  word_t                req_in1  [N_THREADS];
  logic [N_THREADS-1:0] rsp_valid;
  word_t                rsp_data [N_THREADS];

  word_t alu_ctrl;
  word_t alu_in0;
  word_t alu_in1;
  word_t alu_out;

  logic  mem_valid;
  word_t mem_ctrl;
  word_t mem_addr;
  word_t mem_wdata;
  logic  mem_ready;
  word_t mem_rdata;

`ifdef UNIT_ARB_STATS_EN
  logic [31:0] stall_cnt [N_THREADS];
`endif

  modport slave (
    input  req, req_sel, req_ctrl, req_in0, req_in1,
    input  alu_out, mem_ready, mem_rdata,
`ifdef UNIT_ARB_STATS_EN
    output stall_cnt,
`endif
    output rsp_valid, rsp_data,
    output alu_ctrl, alu_in0, alu_in1,
    output mem_valid, mem_ctrl, mem_addr, mem_wdata
  );

  modport master (
    output req, req_sel, req_ctrl, req_in0, req_in1,
    output alu_out, mem_ready, mem_rdata,
`ifdef UNIT_ARB_STATS_EN
    input  stall_cnt,
`endif
    input  rsp_valid, rsp_data,
    input  alu_ctrl, alu_in0, alu_in1,
    input  mem_valid, mem_ctrl, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_arbiter
  import unit_arbiter_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  int           cand;
  logic [W-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand     = rr_index(int'(ptr), k, N);
      cand_idx = W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/unit_arbiter.sv
// Shares one ALU (answered in the grant cycle) and one memory port (one outstanding
// transaction) among N_THREADS threads; optional UNIT_ARB_STATS_EN adds stall counters.
module unit_arbiter
  import unit_arbiter_pkg::*;
#(
  parameter int N_THREADS = 4
) (
  input logic           clk,
  input logic           rst,
  unit_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_THREADS);

  logic [N_THREADS-1:0] alu_cand;
  logic [N_THREADS-1:0] mem_cand;
  logic [N_THREADS-1:0] odd_req;

  logic             alu_win_vld;
  logic [PTR_W-1:0] alu_win;
  logic             mem_win_vld;
  logic [PTR_W-1:0] mem_win;

  logic [PTR_W-1:0] alu_ptr;
  logic [PTR_W-1:0] mem_ptr;

  unit_arb_state_t  state;
  unit_arb_state_t  state_nxt;
  logic             mem_accept;
  logic             mem_done;

  logic [PTR_W-1:0] owner_q;
  word_t            mem_ctrl_q;
  word_t            mem_addr_q;
  word_t            mem_wdata_q;

  logic [N_THREADS-1:0] rsp_valid_c;
  word_t                rsp_data_c [N_THREADS];
  word_t                alu_ctrl_c;
  word_t                alu_in0_c;
  word_t                alu_in1_c;

  // Requests naming neither unit bypass arbitration and are answered with zero.
  always_comb begin
    alu_cand = '0;
    mem_cand = '0;
    odd_req  = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      alu_cand[i] = bus.req[i] && (bus.req_sel[i] == UNIT_SEL_ALU);
      mem_cand[i] = bus.req[i] && (bus.req_sel[i] == UNIT_SEL_MEM);
      odd_req[i]  = bus.req[i] && (bus.req_sel[i] != UNIT_SEL_ALU) &&
                    (bus.req_sel[i] != UNIT_SEL_MEM);
    end
  end

  rr_arbiter #(.N(N_THREADS)) u_alu_rr (
    .req   (alu_cand),
    .ptr   (alu_ptr),
    .valid (alu_win_vld),
    .idx   (alu_win)
  );

  rr_arbiter #(.N(N_THREADS)) u_mem_rr (
    .req   (mem_cand),
    .ptr   (mem_ptr),
    .valid (mem_win_vld),
    .idx   (mem_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNIT_ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The completion cycle never accepts: BUSY only looks at mem_ready.
  always_comb begin
    state_nxt  = state;
    mem_accept = 1'b0;
    mem_done   = 1'b0;
    case (state)
      UNIT_ARB_IDLE: begin
        if (mem_win_vld) begin
          mem_accept = 1'b1;
          state_nxt  = UNIT_ARB_BUSY;
        end
      end
      UNIT_ARB_BUSY: begin
        if (bus.mem_ready) begin
          mem_done  = 1'b1;
          state_nxt = UNIT_ARB_IDLE;
        end
      end
      default: state_nxt = UNIT_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ptr     <= '0;
      mem_ptr     <= '0;
      owner_q     <= '0;
      mem_ctrl_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (alu_win_vld) begin
        alu_ptr <= PTR_W'(ptr_next(int'(alu_win), N_THREADS));
      end
      if (mem_accept) begin
        mem_ptr     <= PTR_W'(ptr_next(int'(mem_win), N_THREADS));
        owner_q     <= mem_win;
        mem_ctrl_q  <= bus.req_ctrl[mem_win];
        mem_addr_q  <= bus.req_in0[mem_win];
        mem_wdata_q <= bus.req_in1[mem_win];
      end
    end
  end

  // Outputs are forced quiet while rst is high, even with requests pending.
  always_comb begin
    rsp_valid_c = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      rsp_data_c[i] = '0;
    end
    alu_ctrl_c = '0;
    alu_in0_c  = '0;
    alu_in1_c  = '0;
    if (!rst) begin
      rsp_valid_c = odd_req;
      if (alu_win_vld) begin
        alu_ctrl_c           = bus.req_ctrl[alu_win];
        alu_in0_c            = bus.req_in0[alu_win];
        alu_in1_c            = bus.req_in1[alu_win];
        rsp_valid_c[alu_win] = 1'b1;
        rsp_data_c[alu_win]  = bus.alu_out;
      end
      if (mem_done) begin
        rsp_valid_c[owner_q] = 1'b1;
        rsp_data_c[owner_q]  = bus.mem_rdata;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_c;
  assign bus.alu_ctrl  = alu_ctrl_c;
  assign bus.alu_in0   = alu_in0_c;
  assign bus.alu_in1   = alu_in1_c;
  assign bus.mem_valid = (state == UNIT_ARB_BUSY);
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef UNIT_ARB_STATS_EN
  logic [31:0] stall_q [N_THREADS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_THREADS; i++) begin
        stall_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_THREADS; i++) begin
        if (bus.req[i] && !rsp_valid_c[i]) begin
          stall_q[i] <= stall_q[i] + 32'd1;
        end
      end
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

endmodule
